// File: rtl/dm_pkg.sv
// Shared Debug Module Interface types and field encodings.
package dm_pkg;

  localparam logic [1:0] DMI_OP_NOP       = 2'd0;
  localparam logic [1:0] DMI_OP_READ      = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE     = 2'd2;

  localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY    = 2'd3;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_rr_picker.sv
// Combinational round-robin pick: first valid at or after the pointer, wrapping.
module dmi_rr_picker #(
  parameter  int NumReq = 2,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] i_valid,
  input  logic [IdxW-1:0]   i_ptr,
  output logic [NumReq-1:0] o_grant,
  output logic [IdxW-1:0]   o_winner,
  output logic              o_any
);

  logic [IdxW-1:0] w_idx;

  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < NumReq; i++) begin
      w_idx = IdxW'((int'(i_ptr) + i) % NumReq);
      if (!o_any && i_valid[w_idx]) begin
        o_any          = 1'b1;
        o_winner       = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one DMI target between NumReq requesters, one transaction at a time.
// IDLE arbitrate | FWD present req | WAIT target resp | RETURN to owner | DRAIN absorb late resp
module dmi_arbiter
  import dm_pkg::*;
#(
  parameter  int NumReq        = 2,
  parameter  int TimeoutCycles = 1024,
  localparam int IdxW          = $clog2(NumReq),
  localparam int TimerWidth    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumReq-1:0]     req_valid_i,
  output logic [NumReq-1:0]     req_ready_o,
  input  dmi_req_t [NumReq-1:0] req_i,
  output logic [NumReq-1:0]     resp_valid_o,
  input  logic [NumReq-1:0]     resp_ready_i,
  output dmi_resp_t             resp_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output dmi_req_t              dmi_req_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  dmi_resp_t             dmi_resp_i,
  output logic                  busy_o,
  output logic [IdxW-1:0]       owner_o,
  output logic                  timeout_o
);

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_WAIT, S_RETURN, S_DRAIN} state_e;

  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

  state_e                r_state, w_state_next;
  logic [IdxW-1:0]       r_ptr, r_owner;
  logic                  r_drop;
  logic [TimerWidth-1:0] r_timer;
  dmi_req_t              r_req;
  dmi_resp_t             r_resp;

  logic [NumReq-1:0]     w_grant;
  logic [IdxW-1:0]       w_winner;
  logic                  w_any;
  logic                  w_accept, w_timer_clr, w_timeout, w_drop_clr, w_timer_last;

  dmi_rr_picker #(.NumReq(NumReq)) u_picker (
    .i_valid  (req_valid_i),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_timer_last = (TimeoutCycles != 0) && (r_timer == TimerLast);

  always_comb begin
    w_state_next     = r_state;
    w_accept         = 1'b0;
    w_timer_clr      = 1'b0;
    w_timeout        = 1'b0;
    w_drop_clr       = 1'b0;
    req_ready_o      = '0;
    resp_valid_o     = '0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Gated by reset so no requester sees ready while the block is held in reset.
        req_ready_o = w_grant & {NumReq{rst_ni}};
        if (w_any) begin
          w_accept     = 1'b1;
          w_state_next = S_FWD;
        end
      end
      S_FWD: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          w_timer_clr  = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          w_state_next = S_RETURN;
        end else if (w_timer_last) begin
          w_timeout    = 1'b1;
          w_state_next = S_RETURN;
        end
      end
      S_RETURN: begin
        resp_valid_o[r_owner] = 1'b1;
        dmi_resp_ready_o      = r_drop;
        w_drop_clr            = r_drop && dmi_resp_valid_i;
        if (resp_ready_i[r_owner]) begin
          if (r_drop && !w_drop_clr) begin
            w_timer_clr  = 1'b1;
            w_state_next = S_DRAIN;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          w_drop_clr   = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_timer_last) begin
          w_drop_clr   = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_drop  <= 1'b0;
      r_timer <= '0;
      r_req   <= '0;
      r_resp  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_req   <= req_i[w_winner];
        r_owner <= w_winner;
        r_ptr   <= (w_winner == IdxW'(NumReq - 1)) ? '0 : w_winner + 1'b1;
      end
      if (w_timer_clr) begin
        r_timer <= '0;
      end else if ((r_state == S_WAIT || r_state == S_DRAIN) && r_timer != '1) begin
        r_timer <= r_timer + 1'b1;
      end
      if (r_state == S_WAIT) begin
        if (dmi_resp_valid_i) begin
          r_resp <= dmi_resp_i;
        end else if (w_timeout) begin
          r_resp <= '{data: 32'h0, resp: DMI_RESP_FAILED};
          r_drop <= 1'b1;
        end
      end
      if (w_drop_clr) r_drop <= 1'b0;
    end
  end

  assign dmi_req_o = r_req;
  assign resp_o    = r_resp;
  assign owner_o   = r_owner;
  assign busy_o    = (r_state != S_IDLE);
  assign timeout_o = w_timeout;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter with two requesters and an 8-cycle response timeout.
module tb_dmi_arbiter;
  import dm_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_ready, resp_valid, resp_ready;
  dmi_req_t  [1:0] req;
  dmi_resp_t       resp;
  logic            dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
  dmi_req_t        dmi_req;
  dmi_resp_t       dmi_resp;
  logic            busy, owner, timeout;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  dmi_arbiter #(.NumReq(2), .TimeoutCycles(8)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_i            (req),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_o           (resp),
    .dmi_req_valid_o  (dmi_req_valid),
    .dmi_req_ready_i  (dmi_req_ready),
    .dmi_req_o        (dmi_req),
    .dmi_resp_valid_i (dmi_resp_valid),
    .dmi_resp_ready_o (dmi_resp_ready),
    .dmi_resp_i       (dmi_resp),
    .busy_o           (busy),
    .owner_o          (owner),
    .timeout_o        (timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dmi_req_t  exp_req;
    dmi_resp_t exp_resp;
    rst_n = 1'b0;
    req_valid = 2'b11; resp_ready = 2'b00; req = '0;
    dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp = '0;
    #3;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_valids", {resp_valid, dmi_req_valid, dmi_resp_ready, busy, timeout}, 6'b0);
    chk("rst_dmi_req", dmi_req, 41'h0);
    chk("rst_resp_owner", {resp, owner}, 35'h0);
    cyc(); cyc();
    req_valid = 2'b00;
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", {busy, req_ready}, 3'b000);

    // Single requester read
    req[1] = '{addr: 7'h11, op: DMI_OP_READ, data: 32'h0};
    req_valid = 2'b10; #1;
    chk("t1_ready_same_cycle", req_ready, 2'b10);
    chk("t1_dmi_valid_not_yet", dmi_req_valid, 1'b0);
    cyc(); req_valid = 2'b00; #1;
    chk("t1_dmi_valid_next", dmi_req_valid, 1'b1);
    chk("t1_dmi_req", dmi_req, {7'h11, 2'd1, 32'h0});
    chk("t1_owner", owner, 1'b1);
    dmi_req_ready = 1'b1; cyc(); dmi_req_ready = 1'b0;
    cyc(); cyc();
    dmi_resp = '{data: 32'hDEADBEEF, resp: DMI_RESP_SUCCESS};
    dmi_resp_valid = 1'b1; #1;
    chk("t1_dmi_resp_ready", dmi_resp_ready, 1'b1);
    cyc(); dmi_resp_valid = 1'b0; resp_ready = 2'b10; #1;
    chk("t1_resp_valid", resp_valid, 2'b10);
    chk("t1_resp", resp, {32'hDEADBEEF, 2'd0});
    cyc(); resp_ready = 2'b00; #1;
    chk("t1_back_idle", {busy, resp_valid}, 3'b000);

    // Contention: grants alternate starting from requester 0
    for (int i = 0; i < 6; i++) begin
      logic [1:0] exp_oh;
      logic [6:0] exp_addr;
      exp_oh   = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 7'(32'h20 + i) : 7'(32'h40 + i);
      req[0] = '{addr: 7'(32'h20 + i), op: DMI_OP_WRITE, data: 32'(i)};
      req[1] = '{addr: 7'(32'h40 + i), op: DMI_OP_READ,  data: 32'h0};
      req_valid = 2'b11; #1;
      chk("rr_ready", req_ready, exp_oh);
      cyc(); #1;
      chk("rr_owner", owner, exp_oh[1]);
      chk("rr_fwd_addr", dmi_req.addr, exp_addr);
      chk("rr_no_accept_busy", req_ready, 2'b00);
      dmi_req_ready = 1'b1; cyc(); dmi_req_ready = 1'b0;
      dmi_resp = '{data: 32'h1000 + i, resp: DMI_RESP_SUCCESS};
      dmi_resp_valid = 1'b1; cyc(); dmi_resp_valid = 1'b0; #1;
      chk("rr_resp_route", resp_valid, exp_oh);
      chk("rr_resp_data", resp.data, 32'h1000 + i);
      resp_ready = exp_oh; cyc(); resp_ready = 2'b00;
    end
    req_valid = 2'b00;

    // Backpressure on both target request and requester response
    exp_req = '{addr: 7'h33, op: DMI_OP_WRITE, data: 32'hCAFEF00D};
    req[0] = exp_req;
    req[1] = '{addr: 7'h7F, op: DMI_OP_NOP, data: 32'h0};
    req_valid = 2'b01; #1;
    chk("bp_ready", req_ready, 2'b01);
    cyc(); req_valid = 2'b11; req[0] = '{addr: 7'h01, op: DMI_OP_READ, data: 32'h9};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_dmi_valid", dmi_req_valid, 1'b1);
      chk("bp_dmi_req_stable", dmi_req, exp_req);
      chk("bp_fwd_no_accept", req_ready, 2'b00);
      cyc();
    end
    dmi_req_ready = 1'b1; cyc(); dmi_req_ready = 1'b0;
    exp_resp = '{data: 32'h55AA55AA, resp: DMI_RESP_BUSY};
    dmi_resp = exp_resp; dmi_resp_valid = 1'b1; cyc(); dmi_resp_valid = 1'b0;
    dmi_resp = '{data: 32'hFFFFFFFF, resp: DMI_RESP_SUCCESS};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_resp_valid", resp_valid, 2'b01);
      chk("bp_resp_stable", resp, exp_resp);
      chk("bp_ret_no_accept", req_ready, 2'b00);
      cyc();
    end
    resp_ready = 2'b01; req_valid = 2'b10; cyc(); resp_ready = 2'b00;

    // Timeout: requester 1 NOP, target never answers in time
    #1;
    chk("to_ready", req_ready, 2'b10);
    cyc(); req_valid = 2'b00; #1;
    chk("to_nop_forwarded", dmi_req, {7'h7F, 2'd0, 32'h0});
    dmi_req_ready = 1'b1; cyc(); dmi_req_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1; pulses += int'(timeout);
      cyc();
    end
    #1;
    chk("to_fires_8th_wait", timeout, 1'b1);
    cyc(); #1; pulses += int'(timeout);
    chk("to_resp_valid", resp_valid, 2'b10);
    chk("to_resp_failed", resp, {32'h0, 2'd2});
    resp_ready = 2'b10; cyc(); resp_ready = 2'b00; #1; pulses += int'(timeout);
    chk("to_drain_busy", {busy, dmi_resp_ready}, 2'b11);
    cyc();
    dmi_resp = '{data: 32'h00000BAD, resp: DMI_RESP_SUCCESS}; dmi_resp_valid = 1'b1; #1;
    pulses += int'(timeout);
    chk("to_late_discarded", resp_valid, 2'b00);
    cyc(); dmi_resp_valid = 1'b0; #1;
    chk("to_drain_to_idle", busy, 1'b0);
    chk("to_single_pulse", pulses, 0);

    // Normal transaction after the drain
    req[0] = '{addr: 7'h01, op: DMI_OP_READ, data: 32'h0};
    req_valid = 2'b01; #1;
    chk("post_to_ready", req_ready, 2'b01);
    cyc(); req_valid = 2'b00;
    dmi_req_ready = 1'b1; cyc(); dmi_req_ready = 1'b0;
    dmi_resp = '{data: 32'h12345678, resp: DMI_RESP_SUCCESS}; dmi_resp_valid = 1'b1;
    cyc(); dmi_resp_valid = 1'b0; resp_ready = 2'b01; #1;
    chk("post_to_resp", {resp_valid, resp}, {2'b01, 32'h12345678, 2'd0});
    cyc(); resp_ready = 2'b00;

    // Response arrives on the final timer cycle
    req[1] = '{addr: 7'h22, op: DMI_OP_READ, data: 32'h0};
    req_valid = 2'b10; #1;
    chk("sim_ready", req_ready, 2'b10);
    cyc(); req_valid = 2'b00;
    dmi_req_ready = 1'b1; cyc(); dmi_req_ready = 1'b0;
    repeat (7) cyc();
    dmi_resp = '{data: 32'h0BADCAFE, resp: DMI_RESP_SUCCESS}; dmi_resp_valid = 1'b1; #1;
    chk("sim_no_timeout", timeout, 1'b0);
    cyc(); dmi_resp_valid = 1'b0; #1;
    chk("sim_resp", {resp_valid, resp}, {2'b10, 32'h0BADCAFE, 2'd0});
    resp_ready = 2'b10; cyc(); resp_ready = 2'b00; #1;
    chk("sim_no_drain", busy, 1'b0);

    // Asynchronous reset while forwarding
    req_valid = 2'b01; #1;
    cyc(); #1;
    chk("rf_in_fwd", dmi_req_valid, 1'b1);
    rst_n = 1'b0; #1;
    chk("rf_valids_low", {dmi_req_valid, busy, req_ready, resp_valid}, 6'b0);
    chk("rf_regs_clear", {dmi_req, owner}, 42'h0);
    cyc();
    req_valid = 2'b11; rst_n = 1'b1; #1;
    chk("rf_ptr_reset", req_ready, 2'b01);
    cyc(); req_valid = 2'b00; #1;
    chk("rf_owner0", {busy, owner}, 2'b10);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
